// File: rtl/e603_dlm_icb_arb2.sv
// e603_dlm_icb_arb2: two-master ICB arbiter in front of the DLM SRAM slave, with in-order response routing
module e603_dlm_icb_arb2 #(
  parameter int ARB_MODE   = 0,
  parameter int OUTS_DEPTH = 2,
  parameter int AW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_icb_cmd_valid,
  output logic          m0_icb_cmd_ready,
  input  logic          m0_icb_cmd_read,
  input  logic [AW-1:0] m0_icb_cmd_addr,
  input  logic [63:0]   m0_icb_cmd_wdata,
  input  logic [7:0]    m0_icb_cmd_wmask,
  input  logic [2:0]    m0_icb_cmd_size,
  input  logic          m0_icb_cmd_lock,
  output logic          m0_icb_rsp_valid,
  input  logic          m0_icb_rsp_ready,
  output logic [63:0]   m0_icb_rsp_rdata,
  output logic          m0_icb_rsp_err,
  input  logic          m1_icb_cmd_valid,
  output logic          m1_icb_cmd_ready,
  input  logic          m1_icb_cmd_read,
  input  logic [AW-1:0] m1_icb_cmd_addr,
  input  logic [63:0]   m1_icb_cmd_wdata,
  input  logic [7:0]    m1_icb_cmd_wmask,
  input  logic [2:0]    m1_icb_cmd_size,
  input  logic          m1_icb_cmd_lock,
  output logic          m1_icb_rsp_valid,
  input  logic          m1_icb_rsp_ready,
  output logic [63:0]   m1_icb_rsp_rdata,
  output logic          m1_icb_rsp_err,
  output logic          s_icb_cmd_valid,
  input  logic          s_icb_cmd_ready,
  output logic          s_icb_cmd_read,
  output logic [AW-1:0] s_icb_cmd_addr,
  output logic [63:0]   s_icb_cmd_wdata,
  output logic [7:0]    s_icb_cmd_wmask,
  output logic [2:0]    s_icb_cmd_size,
  input  logic          s_icb_rsp_valid,
  output logic          s_icb_rsp_ready,
  input  logic [63:0]   s_icb_rsp_rdata,
  input  logic          s_icb_rsp_err,
  output logic          arb_active
);
  localparam int PW = OUTS_DEPTH > 1 ? $clog2(OUTS_DEPTH) : 1;
  logic [PW-1:0] wptr, rptr;
  logic [2:0] cnt;
  logic [OUTS_DEPTH-1:0] ids;
  logic rr_ptr, gnt_hold, gnt_r, lock_vld, lock_id;
  logic gnt, gnt_vld, gnt_lock, full, empty, hs, pop, head;
  always_comb begin
    full     = cnt == 3'(OUTS_DEPTH);
    empty    = cnt == 3'd0;
    gnt      = lock_vld ? lock_id :
               gnt_hold ? gnt_r :
               (m0_icb_cmd_valid ^ m1_icb_cmd_valid) ? m1_icb_cmd_valid :
               (ARB_MODE == 1) ? 1'b0 : rr_ptr;
    gnt_vld  = gnt ? m1_icb_cmd_valid : m0_icb_cmd_valid;
    gnt_lock = gnt ? m1_icb_cmd_lock : m0_icb_cmd_lock;
    // Only the granted master may present, so a lock owner that goes idle cannot leak a phantom beat
    s_icb_cmd_valid  = rst_n & gnt_vld & ~full;
    s_icb_cmd_read   = gnt ? m1_icb_cmd_read  : m0_icb_cmd_read;
    s_icb_cmd_addr   = gnt ? m1_icb_cmd_addr  : m0_icb_cmd_addr;
    s_icb_cmd_wdata  = gnt ? m1_icb_cmd_wdata : m0_icb_cmd_wdata;
    s_icb_cmd_wmask  = gnt ? m1_icb_cmd_wmask : m0_icb_cmd_wmask;
    s_icb_cmd_size   = gnt ? m1_icb_cmd_size  : m0_icb_cmd_size;
    m0_icb_cmd_ready = rst_n & ~gnt & s_icb_cmd_ready & ~full;
    m1_icb_cmd_ready = rst_n & gnt & s_icb_cmd_ready & ~full;
    hs               = s_icb_cmd_valid & s_icb_cmd_ready;
    head             = ids[rptr];
    m0_icb_rsp_valid = rst_n & ~empty & ~head & s_icb_rsp_valid;
    m1_icb_rsp_valid = rst_n & ~empty & head & s_icb_rsp_valid;
    // With nothing outstanding a stray response is swallowed
    s_icb_rsp_ready  = rst_n & (empty | (head ? m1_icb_rsp_ready : m0_icb_rsp_ready));
    m0_icb_rsp_rdata = s_icb_rsp_rdata;
    m1_icb_rsp_rdata = s_icb_rsp_rdata;
    m0_icb_rsp_err   = s_icb_rsp_err;
    m1_icb_rsp_err   = s_icb_rsp_err;
    pop              = s_icb_rsp_valid & s_icb_rsp_ready & ~empty;
    arb_active       = rst_n & (m0_icb_cmd_valid | m1_icb_cmd_valid | ~empty);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rr_ptr   <= 1'b0;
      gnt_hold <= 1'b0;
      gnt_r    <= 1'b0;
      lock_vld <= 1'b0;
      lock_id  <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      ids      <= '0;
    end else begin
      if (hs) begin
        rr_ptr    <= ~gnt;
        lock_vld  <= gnt_lock;
        lock_id   <= gnt;
        gnt_hold  <= 1'b0;
        ids[wptr] <= gnt;
        wptr      <= wptr == PW'(OUTS_DEPTH - 1) ? '0 : wptr + PW'(1);
      end else if (s_icb_cmd_valid) begin
        gnt_hold <= 1'b1;
        gnt_r    <= gnt;
      end
      if (pop) rptr <= rptr == PW'(OUTS_DEPTH - 1) ? '0 : rptr + PW'(1);
      cnt <= cnt + 3'(hs) - 3'(pop);
    end
  a_rsp_no_outstanding: assert property (@(posedge clk) disable iff (!rst_n) !(s_icb_rsp_valid && empty));
endmodule

// File: tb/tb_e603_dlm_icb_arb2.sv
// tb_e603_dlm_icb_arb2: per-cycle vector table plus scoreboarded responses from a 1-cycle SRAM model
module tb_e603_dlm_icb_arb2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic m0_v = 0, m0_rdy, m0_rv, m0_rr = 1, m0_err;
  logic m1_v = 0, m1_rdy, m1_rv, m1_rr = 1, m1_err, m1_lock = 0;
  logic [15:0] m0_a = 0, m1_a = 0, s_a;
  logic [63:0] m0_rd, m1_rd, s_wd, s_rd = 0;
  logic s_v, s_rdy = 0, s_rd_n, s_rv = 0, s_rr;
  logic [7:0] s_wm;
  logic [2:0] s_sz;
  logic act;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;
  e603_dlm_icb_arb2 dut (
    .clk(clk), .rst_n(rst_n),
    .m0_icb_cmd_valid(m0_v), .m0_icb_cmd_ready(m0_rdy), .m0_icb_cmd_read(1'b1),
    .m0_icb_cmd_addr(m0_a), .m0_icb_cmd_wdata(64'h0), .m0_icb_cmd_wmask(8'h00),
    .m0_icb_cmd_size(3'd3), .m0_icb_cmd_lock(1'b0),
    .m0_icb_rsp_valid(m0_rv), .m0_icb_rsp_ready(m0_rr), .m0_icb_rsp_rdata(m0_rd), .m0_icb_rsp_err(m0_err),
    .m1_icb_cmd_valid(m1_v), .m1_icb_cmd_ready(m1_rdy), .m1_icb_cmd_read(1'b0),
    .m1_icb_cmd_addr(m1_a), .m1_icb_cmd_wdata(64'h1122334455667788), .m1_icb_cmd_wmask(8'hff),
    .m1_icb_cmd_size(3'd3), .m1_icb_cmd_lock(m1_lock),
    .m1_icb_rsp_valid(m1_rv), .m1_icb_rsp_ready(m1_rr), .m1_icb_rsp_rdata(m1_rd), .m1_icb_rsp_err(m1_err),
    .s_icb_cmd_valid(s_v), .s_icb_cmd_ready(s_rdy), .s_icb_cmd_read(s_rd_n), .s_icb_cmd_addr(s_a),
    .s_icb_cmd_wdata(s_wd), .s_icb_cmd_wmask(s_wm), .s_icb_cmd_size(s_sz),
    .s_icb_rsp_valid(s_rv), .s_icb_rsp_ready(s_rr), .s_icb_rsp_rdata(s_rd), .s_icb_rsp_err(1'b0),
    .arb_active(act)
  );
  function automatic logic [63:0] mem(input logic [15:0] a);
    return {16'hd00d, a, ~a, a ^ 16'h5a5a};
  endfunction
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nvec++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", n, a, e);
    end
  endtask
  typedef struct {logic m; logic [15:0] a;} exp_t;
  exp_t sb[$];
  logic [15:0] slv[$];
  task automatic rsp_chk(input logic m, input logic [63:0] d);
    exp_t e;
    if (sb.size() == 0) chk("rsp_unexpected", {63'd0, m}, 64'hdead);
    else begin
      e = sb.pop_front();
      chk("rsp_master", {63'd0, m}, {63'd0, e.m});
      chk("rsp_rdata", d, mem(e.a));
    end
  endtask
  // Scoreboard pushes on master-side acceptance; the slave model answers one cycle after its handshake
  always @(posedge clk) begin
    if (!rst_n) begin
      sb.delete();
      slv.delete();
    end else begin
      if (m0_v && m0_rdy) sb.push_back('{1'b0, m0_a});
      if (m1_v && m1_rdy) sb.push_back('{1'b1, m1_a});
      if (s_v && s_rdy) slv.push_back(s_a);
      if (s_rv && s_rr) void'(slv.pop_front());
      if (m0_rv && m0_rr) rsp_chk(1'b0, m0_rd);
      if (m1_rv && m1_rr) rsp_chk(1'b1, m1_rd);
    end
    #1;
    s_rv = slv.size() != 0;
    s_rd = slv.size() != 0 ? mem(slv[0]) : 64'h0;
  end
  always @(negedge clk)
    if (rst_n && (m0_rv || m1_rv)) begin
      if (sb.size() == 0) chk("rsp_route_empty", {62'd0, m1_rv, m0_rv}, 64'd0);
      else chk("rsp_route", {62'd0, m1_rv, m0_rv}, sb[0].m ? 64'd2 : 64'd1);
    end
  typedef struct {
    logic m0v; logic [15:0] m0a; logic m1v, m1l; logic [15:0] m1a;
    logic sr, r0, r1, e0, e1; logic [1:0] es; logic [15:0] ea;
  } vec_t;
  vec_t tv[$];
  function automatic vec_t mk(input logic m0v, input logic [15:0] m0a, input logic m1v, input logic m1l,
                              input logic [15:0] m1a, input logic sr, input logic r0, input logic r1,
                              input logic e0, input logic e1, input logic [1:0] es, input logic [15:0] ea);
    return '{m0v, m0a, m1v, m1l, m1a, sr, r0, r1, e0, e1, es, ea};
  endfunction
  initial begin
    // single master back-to-back
    tv.push_back(mk(1, 16'h0010, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 1, 16'h0010));
    tv.push_back(mk(1, 16'h0018, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 1, 16'h0018));
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0000));
    // round-robin contention (rr points at m1 after m0's last win)
    tv.push_back(mk(1, 16'h0100, 1, 0, 16'h8100, 1, 1, 1, 0, 1, 1, 16'h8100));
    tv.push_back(mk(1, 16'h0100, 1, 0, 16'h8108, 1, 1, 1, 1, 0, 1, 16'h0100));
    tv.push_back(mk(1, 16'h0108, 1, 0, 16'h8108, 1, 1, 1, 0, 1, 1, 16'h8108));
    tv.push_back(mk(1, 16'h0108, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 1, 16'h0108));
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0000));
    // grant hold: m1 stalled, then m0 joins while rr points at m0
    tv.push_back(mk(0, 16'h0000, 1, 0, 16'h8180, 1, 1, 1, 0, 1, 1, 16'h8180));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0, 16'h0000, 1, 0, 16'h8200, 0, 1, 1, 0, 0, 1, 16'h8200));
    tv.push_back(mk(1, 16'h0200, 1, 0, 16'h8200, 0, 1, 1, 0, 0, 1, 16'h8200));
    tv.push_back(mk(1, 16'h0200, 1, 0, 16'h8200, 1, 1, 1, 0, 1, 1, 16'h8200));
    tv.push_back(mk(1, 16'h0200, 1, 0, 16'h8208, 1, 1, 1, 1, 0, 1, 16'h0200));
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0000));
    // lock held by idle m1 blocks m0
    tv.push_back(mk(0, 16'h0000, 1, 1, 16'h8300, 1, 1, 1, 0, 1, 1, 16'h8300));
    for (int i = 0; i < 5; i++) tv.push_back(mk(1, 16'h0300, 0, 0, 16'h0000, 1, 1, 1, 0, 1, 2, 16'h0000));
    tv.push_back(mk(1, 16'h0300, 1, 0, 16'h8308, 1, 1, 1, 0, 1, 1, 16'h8308));
    tv.push_back(mk(1, 16'h0300, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 1, 16'h0300));
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0000));
    // outstanding FIFO full with m0 response backpressure
    tv.push_back(mk(1, 16'h0400, 0, 0, 16'h0000, 1, 0, 1, 1, 0, 1, 16'h0400));
    tv.push_back(mk(1, 16'h0408, 0, 0, 16'h0000, 1, 0, 1, 1, 0, 1, 16'h0408));
    tv.push_back(mk(1, 16'h0410, 0, 0, 16'h0000, 1, 0, 1, 0, 0, 0, 16'h0000));
    tv.push_back(mk(1, 16'h0410, 0, 0, 16'h0000, 1, 1, 1, 0, 0, 0, 16'h0000));
    tv.push_back(mk(1, 16'h0410, 0, 0, 16'h0000, 1, 1, 1, 1, 0, 1, 16'h0410));
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0000));
    tv.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0000));
    // reset values, with a master knocking while reset is held
    repeat (2) @(posedge clk);
    #1;
    m0_v = 1; s_rdy = 1;
    #1;
    chk("rst_s_valid", {63'd0, s_v}, 0);
    chk("rst_m0_ready", {63'd0, m0_rdy}, 0);
    chk("rst_s_rsp_ready", {63'd0, s_rr}, 0);
    chk("rst_active", {63'd0, act}, 0);
    m0_v = 0; s_rdy = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("idle_s_valid", {63'd0, s_v}, 0);
    chk("idle_rsp_valid", {62'd0, m1_rv, m0_rv}, 0);
    chk("idle_active", {63'd0, act}, 0);
    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk);
      #1;
      m0_v = tv[i].m0v; m0_a = tv[i].m0a; m1_v = tv[i].m1v; m1_lock = tv[i].m1l; m1_a = tv[i].m1a;
      s_rdy = tv[i].sr; m0_rr = tv[i].r0; m1_rr = tv[i].r1;
      @(negedge clk);
      chk($sformatf("v%0d_m0_ready", i), {63'd0, m0_rdy}, {63'd0, tv[i].e0});
      chk($sformatf("v%0d_m1_ready", i), {63'd0, m1_rdy}, {63'd0, tv[i].e1});
      if (tv[i].es != 2) chk($sformatf("v%0d_s_valid", i), {63'd0, s_v}, {62'd0, tv[i].es});
      if (tv[i].es == 1) chk($sformatf("v%0d_s_addr", i), {48'd0, s_a}, {48'd0, tv[i].ea});
    end
    // m1 response stalled for 4 cycles
    @(posedge clk);
    #1;
    m1_v = 1; m1_a = 16'h8500; s_rdy = 1; m1_rr = 0;
    @(negedge clk);
    chk("bp_m1_ready", {63'd0, m1_rdy}, 1);
    @(posedge clk);
    #1;
    m1_v = 0; s_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_s_rsp_ready", {63'd0, s_rr}, 0);
      chk("bp_m1_rsp_valid", {63'd0, m1_rv}, 1);
      chk("bp_rdata", m1_rd, mem(16'h8500));
      if (i == 3) begin
        m0_v = 1; m0_a = 16'h0600;
      end
    end
    // asynchronous reset mid-stream
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_s_valid", {63'd0, s_v}, 0);
    chk("mid_rst_rsp_valid", {62'd0, m1_rv, m0_rv}, 0);
    chk("mid_rst_active", {63'd0, act}, 0);
    m0_v = 0; m1_rr = 1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_active", {63'd0, act}, 0);
    @(posedge clk);
    #1;
    m0_v = 1; m0_a = 16'h0700; s_rdy = 1; m0_rr = 1;
    @(negedge clk);
    chk("post_rst_m0_ready", {63'd0, m0_rdy}, 1);
    @(posedge clk);
    #1;
    m0_v = 0; s_rdy = 0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 0);
    chk("final_active", {63'd0, act}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
